// File: rtl/udlx_mem_pkg.sv
// Shared encodings for the uDLX data-memory access path: access sizes,
// sequencer states, base byte-enable patterns and the load extension helper.
package udlx_mem_pkg;

   localparam int DW = 32;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Byte-enable patterns for offset 0; shifted right by the byte offset.
   localparam logic [3:0] BE_BYTE = 4'b1000;
   localparam logic [3:0] BE_HALF = 4'b1100;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   // Widens a byte (is_half=0, value in [7:0]) or a half to a full word.
   function automatic logic [DW-1:0] lane_extend(input logic [15:0] val,
                                                 input logic       is_half,
                                                 input logic       sign_ext);
      logic [DW-1:0] res;
      if (is_half)
         res = {{16{sign_ext & val[15]}}, val};
      else
         res = {{24{sign_ext & val[7]}}, val[7:0]};
      return res;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables, store replication, load
// extraction/extension and the alignment check for one access.
module mem_lane_align
   import udlx_mem_pkg::*;
(
   input  logic [1:0]    size,
   input  logic [1:0]    offset,
   input  logic          sign_ext,
   input  logic [DW-1:0] wr_data,
   input  logic [DW-1:0] rd_word,
   output logic [3:0]    be,
   output logic [DW-1:0] wdata,
   output logic [DW-1:0] rd_ext,
   output logic          aligned
);

   logic [7:0] lane [4];

   // lane[gi] holds bits 8*gi+7:8*gi; big-endian offset o lives in lane[3-o].
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = rd_word[8*gi +: 8];
      end
   endgenerate

   always_comb begin
      be      = BE_WORD;
      wdata   = wr_data;
      rd_ext  = rd_word;
      aligned = 1'b1;
      unique case (size)
         SZ_BYTE: begin
            be     = BE_BYTE >> offset;
            wdata  = {4{wr_data[7:0]}};
            rd_ext = lane_extend({8'h00, lane[~offset]}, 1'b0, sign_ext);
         end
         SZ_HALF: begin
            be      = BE_HALF >> offset;
            wdata   = {2{wr_data[15:0]}};
            rd_ext  = offset[1] ? lane_extend({lane[1], lane[0]}, 1'b1, sign_ext)
                                : lane_extend({lane[3], lane[2]}, 1'b1, sign_ext);
            aligned = ~offset[0];
         end
         SZ_WORD, 2'b11: begin
            be      = BE_WORD;
            wdata   = wr_data;
            rd_ext  = rd_word;
            aligned = (offset == 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// uDLX MEM-stage data-memory sequencer: one outstanding req/ack access per
// instruction, with alignment faulting, timeout abort and pipeline stall.
module mem_access_ctrl
   import udlx_mem_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_rd_en_in,
   input  logic                  mem_wr_en_in,
   input  logic [1:0]            mem_size_in,
   input  logic                  mem_signed_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [DATA_WIDTH-1:0] wr_data_in,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_ack,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic                  stall_out,
   output logic                  done_out,
   output logic                  misalign_out,
   output logic                  timeout_out
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   mem_state_t state_reg, state_next;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [3:0]            be_reg;
   logic [DATA_WIDTH-1:0] wdata_reg;
   logic                  we_reg;
   logic [1:0]            size_reg;
   logic [1:0]            off_reg;
   logic                  signed_reg;
   logic [DATA_WIDTH-1:0] rd_data_reg;
   logic [CNT_W-1:0]      cnt_reg;
   logic                  misalign_reg;
   logic                  timeout_reg;

   logic                  request;
   logic                  in_idle;
   logic                  accept;
   logic                  misalign_next;
   logic                  timeout_hit;
   logic                  load_done;

   logic [1:0]            al_size;
   logic [1:0]            al_off;
   logic                  al_sign;
   logic [3:0]            al_be;
   logic [DATA_WIDTH-1:0] al_wdata;
   logic [DATA_WIDTH-1:0] al_rd_ext;
   logic                  al_aligned;

   assign request = mem_rd_en_in | mem_wr_en_in;
   assign in_idle = (state_reg == ST_IDLE);

   // The aligner sees the live request in IDLE and the latched access afterwards,
   // so one instance serves both the store set-up and the load return.
   assign al_size = in_idle ? mem_size_in   : size_reg;
   assign al_off  = in_idle ? addr_in[1:0]  : off_reg;
   assign al_sign = in_idle ? mem_signed_in : signed_reg;

   mem_lane_align u_lane_align (
      .size     (al_size),
      .offset   (al_off),
      .sign_ext (al_sign),
      .wr_data  (wr_data_in),
      .rd_word  (dmem_rdata),
      .be       (al_be),
      .wdata    (al_wdata),
      .rd_ext   (al_rd_ext),
      .aligned  (al_aligned)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next    = state_reg;
      accept        = 1'b0;
      misalign_next = 1'b0;
      timeout_hit   = 1'b0;
      load_done     = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (request) begin
               if (al_aligned) begin
                  accept     = 1'b1;
                  state_next = ST_REQ;
               end else begin
                  misalign_next = 1'b1;
               end
            end
         end
         ST_REQ: begin
            // An ack on the final permitted cycle still completes normally.
            if (dmem_ack) begin
               load_done  = ~we_reg;
               state_next = ST_DONE;
            end else if (cnt_reg == CNT_LAST) begin
               timeout_hit = 1'b1;
               state_next  = ST_IDLE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg     <= '0;
         be_reg       <= '0;
         wdata_reg    <= '0;
         we_reg       <= 1'b0;
         size_reg     <= SZ_BYTE;
         off_reg      <= 2'b00;
         signed_reg   <= 1'b0;
         rd_data_reg  <= '0;
         cnt_reg      <= '0;
         misalign_reg <= 1'b0;
         timeout_reg  <= 1'b0;
      end else begin
         misalign_reg <= misalign_next;
         timeout_reg  <= timeout_hit;
         if (accept) begin
            addr_reg   <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
            be_reg     <= al_be;
            wdata_reg  <= al_wdata;
            we_reg     <= mem_wr_en_in;
            size_reg   <= mem_size_in;
            off_reg    <= addr_in[1:0];
            signed_reg <= mem_signed_in;
            cnt_reg    <= '0;
         end else if (state_reg == ST_REQ && cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (load_done)
            rd_data_reg <= al_rd_ext;
         else if (timeout_hit)
            rd_data_reg <= '0;
      end
   end

   assign dmem_req     = (state_reg == ST_REQ);
   assign dmem_we      = we_reg;
   assign dmem_addr    = addr_reg;
   assign dmem_be      = be_reg;
   assign dmem_wdata   = wdata_reg;
   assign rd_data_out  = rd_data_reg;
   assign done_out     = (state_reg == ST_DONE);
   assign misalign_out = misalign_reg;
   assign timeout_out  = timeout_reg;
   assign stall_out    = accept | (state_reg == ST_REQ);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a driver issues loads/stores and queues
// expected memory requests and completion events; a monitor checks them.
module tb_mem_access_ctrl;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_rd_en_in = 1'b0;
   logic        mem_wr_en_in = 1'b0;
   logic [1:0]  mem_size_in = 2'b00;
   logic        mem_signed_in = 1'b0;
   logic [31:0] addr_in = '0;
   logic [31:0] wr_data_in = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic [31:0] rd_data_out;
   logic        stall_out;
   logic        done_out;
   logic        misalign_out;
   logic        timeout_out;

   mem_access_ctrl #(
      .DATA_WIDTH     (32),
      .ADDR_WIDTH     (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mem_rd_en_in  (mem_rd_en_in),
      .mem_wr_en_in  (mem_wr_en_in),
      .mem_size_in   (mem_size_in),
      .mem_signed_in (mem_signed_in),
      .addr_in       (addr_in),
      .wr_data_in    (wr_data_in),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_be       (dmem_be),
      .dmem_wdata    (dmem_wdata),
      .dmem_ack      (dmem_ack),
      .dmem_rdata    (dmem_rdata),
      .rd_data_out   (rd_data_out),
      .stall_out     (stall_out),
      .done_out      (done_out),
      .misalign_out  (misalign_out),
      .timeout_out   (timeout_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          wt;
      logic [31:0] rdata;
      int          len;
   } req_t;

   // ev is {done, timeout, misalign}
   typedef struct {
      logic [2:0]  ev;
      logic [31:0] rd;
      int          stall;
   } rsp_t;

   req_t        req_q[$];
   rsp_t        rsp_q[$];
   int          total = 0;
   int          bad = 0;
   int          txn_no = 0;
   logic [31:0] model_rd = '0;
   logic        tb_ack = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor and memory responder, sampling on the falling edge.
   req_t cur;
   rsp_t mon_e;
   int   req_cnt = 0;
   int   stall_acc = 0;
   logic ack_now;

   always @(negedge clk) begin
      ack_now = 1'b0;
      if (rst) begin
         req_cnt   = 0;
         stall_acc = 0;
      end else begin
         if (done_out | timeout_out | misalign_out) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_event", {29'b0, done_out, timeout_out, misalign_out}, 32'h0);
            end else begin
               mon_e = rsp_q.pop_front();
               check("event_kind", {29'b0, done_out, timeout_out, misalign_out}, {29'b0, mon_e.ev});
               check("rd_data_out", rd_data_out, mon_e.rd);
               check("stall_cycles", stall_acc, mon_e.stall);
            end
            stall_acc = 0;
         end
         stall_acc += int'(stall_out);
         if (dmem_req) begin
            if (req_cnt == 0) begin
               if (req_q.size() == 0) begin
                  check("unexpected_req", {31'b0, dmem_req}, 32'h0);
                  cur.wt = 1000;
               end else begin
                  cur = req_q.pop_front();
               end
            end
            check("dmem_addr", dmem_addr, cur.addr);
            check("dmem_be", {28'b0, dmem_be}, {28'b0, cur.be});
            check("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
            if (cur.we)
               check("dmem_wdata", dmem_wdata, cur.wdata);
            ack_now = (req_cnt == cur.wt);
            req_cnt++;
         end else if (req_cnt != 0) begin
            check("req_cycles", req_cnt, cur.len);
            req_cnt = 0;
         end
      end
      dmem_ack   = ack_now | tb_ack;
      dmem_rdata = ack_now ? cur.rdata : $urandom;
   end

   // Reference: big-endian lanes computed with plain shifts and masks.
   task automatic run_txn(input bit rd, input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wd, input int wt,
                          input logic [31:0] rdata);
      int              off, sz;
      bit              aligned, fin;
      longint unsigned v, mask;
      req_t            r;
      rsp_t            e;
      off     = int'(addr[1:0]);
      sz      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      aligned = (off % sz) == 0;
      if (!aligned) begin
         e.ev = 3'b001; e.rd = model_rd; e.stall = 0;
         rsp_q.push_back(e);
      end else begin
         r.we    = wr;
         r.addr  = addr & ~32'h3;
         r.be    = 4'(((1 << sz) - 1) << (4 - sz - off));
         r.wdata = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
                   (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
         r.wt    = wt;
         r.rdata = rdata;
         if (wt >= T) begin
            r.len = T; model_rd = '0; e.ev = 3'b010;
         end else begin
            r.len = wt + 1; e.ev = 3'b100;
            if (!wr) begin
               mask = (64'd1 << (8 * sz)) - 64'd1;
               v = (64'(rdata) >> (8 * (4 - sz - off))) & mask;
               if (sgn && sz < 4 && v[8*sz-1]) v = v | ~mask;
               model_rd = v[31:0];
            end
         end
         e.rd = model_rd; e.stall = 1 + r.len;
         req_q.push_back(r);
         rsp_q.push_back(e);
      end
      @(posedge clk); #1;
      mem_rd_en_in = rd; mem_wr_en_in = wr; mem_size_in = size;
      mem_signed_in = sgn; addr_in = addr; wr_data_in = wd;
      if (!aligned) begin
         @(posedge clk); #1;
      end else begin
         fin = 1'b0;
         for (int i = 0; i < 40 && !fin; i++) begin
            @(posedge clk); #1;
            if (done_out || timeout_out) fin = 1'b1;
         end
         check("txn_complete", {31'b0, fin}, 32'h1);
      end
      mem_rd_en_in = 1'b0; mem_wr_en_in = 1'b0;
      $display("txn %0d: rd=%0b wr=%0b size=%0d signed=%0b addr=0x%08h wdata=0x%08h wait=%0d expect_ev=%03b expect_rd=0x%08h",
               txn_no, rd, wr, size, sgn, addr, wd, wt, e.ev, e.rd);
      txn_no++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fin;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
      check("rst_dmem_we", {31'b0, dmem_we}, 32'h0);
      check("rst_dmem_addr", dmem_addr, 32'h0);
      check("rst_dmem_be", {28'b0, dmem_be}, 32'h0);
      check("rst_dmem_wdata", dmem_wdata, 32'h0);
      check("rst_rd_data", rd_data_out, 32'h0);
      check("rst_pulses", {29'b0, done_out, misalign_out, timeout_out}, 32'h0);
      check("rst_stall", {31'b0, stall_out}, 32'h0);
      rst = 1'b0;

      run_txn(1, 0, 2'b10, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF);
      run_txn(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 32'h000000F0);
      run_txn(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 32'h000000F0);
      run_txn(0, 1, 2'b01, 0, 32'h202, 32'h00001234, 0, 32'h0);
      run_txn(1, 0, 2'b10, 0, 32'h102, 32'h0, 0, 32'h0);
      run_txn(1, 0, 2'b01, 1, 32'h101, 32'h0, 0, 32'h0);
      run_txn(1, 0, 2'b10, 0, 32'h104, 32'h0, 1000, 32'h0);
      run_txn(1, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 1, 32'h11111111);
      run_txn(1, 0, 2'b11, 0, 32'h408, 32'h0, T - 1, 32'h80402010);
      run_txn(1, 0, 2'b01, 1, 32'h40A, 32'h0, 0, 32'h1234ABCD);

      for (int k = 0; k < 60; k++) begin
         int sel;
         sel = $urandom_range(0, 3);
         run_txn(sel != 1, sel == 1 || sel == 2, 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 255)),
                 $urandom, $urandom_range(0, 5), $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      // Reset during REQ: the access is abandoned and a late ack is ignored.
      cur.len = 0;
      req_q.push_back('{we: 1'b0, addr: 32'h300, be: 4'hF, wdata: 32'h0, wt: 1000,
                        rdata: 32'h0, len: 0});
      @(posedge clk); #1;
      mem_rd_en_in = 1'b1; mem_size_in = 2'b10; mem_signed_in = 1'b0; addr_in = 32'h300;
      fin = 1'b0;
      for (int i = 0; i < 10 && !fin; i++) begin
         @(posedge clk); #1;
         if (dmem_req) fin = 1'b1;
      end
      check("reset_test_req_seen", {31'b0, fin}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1; mem_rd_en_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      check("req_after_rst", {31'b0, dmem_req}, 32'h0);
      check("rd_after_rst", rd_data_out, 32'h0);
      tb_ack = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         check("no_done_late_ack", {31'b0, done_out}, 32'h0);
      end
      tb_ack = 1'b0;
      $display("txn %0d: reset during REQ at addr=0x00000300 with late ack", txn_no);
      repeat (3) @(posedge clk);
      #1;
      check("queues_drained", 32'(req_q.size() + rsp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Data-memory access sequencer for the uDLX Memory Access stage. Takes one load/store per instruction from the MEM stage, checks alignment, and drives a single-outstanding req/ack transaction to the external data memory. Handles DLX byte/half/word sizes and sign/zero extension, and stalls the pipeline until the access completes, faults or times out.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT_CYCLES, 255, number of REQ cycles without ack before abort; minimum 1.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_rd_en_in  in  1  load request, level.
- mem_wr_en_in  in  1  store request, level; wins over rd if both are set.
- mem_size_in  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- mem_signed_in  in  1  sign-extend loads (LB/LH); 0 zero-extends (LBU/LHU).
- addr_in  in  ADDR_WIDTH  byte address.
- wr_data_in  in  DATA_WIDTH  store data, right-justified.
- dmem_req  out  1  transaction request.
- dmem_we  out  1  1 store, 0 load.
- dmem_addr  out  ADDR_WIDTH  word address, {addr[ADDR_WIDTH-1:2],2'b00}.
- dmem_be  out  4  byte enables; be[3]=bits 31:24.
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data.
- dmem_ack  in  1  transaction complete; rdata is valid in the same cycle.
- dmem_rdata  in  DATA_WIDTH  read word.
- rd_data_out  out  DATA_WIDTH  extended load result.
- stall_out  out  1  hold pipeline registers upstream of and including MEM.
- done_out  out  1  one-cycle completion pulse.
- misalign_out  out  1  one-cycle alignment-fault pulse.
- timeout_out  out  1  one-cycle timeout pulse.

## Operation
- **Byte order:** big-endian. Address offset 0 maps to bits 31:24.
- **Alignment:** half requires addr[0]=0. Word requires addr[1:0]=0.
- **Byte enables:**
  - Byte: 1000 >> addr[1:0].
  - Half: 1100 (offset 0) or 0011 (offset 2).
  - Word: 1111.
- **Store data:** a byte is replicated to all 4 lanes; a half is replicated to both halves.
- **Load data:** the lane selected by the latched offset is extracted, then sign- or zero-extended per the latched mem_signed.
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - Request present and aligned: latch addr, size, signed, we, wdata and be; go to REQ.
  - Request present and misaligned: pulse misalign_out next cycle, issue no memory access, stay in IDLE.
  - dmem_ack is ignored.
- **REQ:**
  - dmem_req=1 and all dmem_* outputs are stable until exit.
  - On dmem_ack: for a load, capture the extended dmem_rdata into rd_data_out. Go to DONE.
  - No ack by the TIMEOUT_CYCLES-th REQ cycle: drop req, pulse timeout_out, set rd_data_out=0, go to IDLE.
  - Input changes during REQ are ignored.
- **DONE:** done_out=1 and dmem_req=0, then go to IDLE. Requests are ignored in DONE because the same instruction is still presented.
- **stall_out (combinational):** (IDLE & request & aligned) | REQ.
- **rd_data_out:** holds its value until the next load completes or a timeout occurs. Stores leave it unchanged.

## Timing
- **Reset values:** state IDLE; dmem_req, dmem_we, done_out, misalign_out, timeout_out and stall_out are 0; dmem_addr, dmem_be, dmem_wdata and rd_data_out are 0; timeout counter 0.
- **Reset mid-transaction:** forces IDLE with dmem_req=0 on the next edge. A late ack afterwards is ignored.
- **Minimum latency:** 3 cycles (IDLE accept, REQ with immediate ack, DONE). Each added wait state adds 1 cycle.
- **done_out:** asserted in the cycle stall_out first drops, so the pipeline advances at the end of DONE.
- **Misaligned request:** stall_out stays 0, so the instruction advances. The misalign_out pulse appears in the following cycle.
- **Timeout counter:** cleared on REQ entry. It saturates and never wraps.

## Structure
- Package udlx_mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - the be base constants.
- One combinational sub-module, mem_lane_align. It computes be, store replication, load extraction/extension and the alignment check, and is shared by the store and load paths. The FSM and timeout counter live in the top.

## Test plan
- **Word load:** LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → req held 3 cycles, be=1111, rd_data_out=0xDEADBEEF, done pulse, stall high 4 cycles.
- **Signed/unsigned byte load:** LB and LBU at addr 0x103, rdata 0x000000F0 → be=0001; rd_data_out 0xFFFFFFF0 for LB and 0x000000F0 for LBU.
- **Half store:** SH addr 0x202, wdata 0x00001234, immediate ack → dmem_we=1, be=0011, dmem_wdata=0x12341234, dmem_addr=0x200; 3-cycle latency.
- **Misaligned:** LW at 0x102 and LH at 0x101 → no dmem_req, stall 0, misalign_out 1-cycle pulse each.
- **Timeout:** TIMEOUT_CYCLES=4, no ack → req exactly 4 cycles, timeout_out pulse, rd_data_out=0, back to IDLE.
- **Reset and conflicts:**
  - rst asserted in REQ → dmem_req 0 next cycle; a subsequent ack produces no done_out.
  - rd and wr both set → store is performed.
